// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory port between instruction fetch and load/store requesters.
// Optional REQ/WAIT timeout with bus_err pulse is enabled by defining MEM_PORT_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_stall,
  output logic        data_stall,
  output logic        bus_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic          owner_data;
  logic [SW-1:0] starve_cnt;
  logic          grant_data;
  logic          fin;
  logic [31:0]   fin_rdata;

  // Data wins unless fetch has already been passed over STARVE_LIMIT times in a row.
  assign grant_data = data_req & (~inst_req | (starve_cnt != STARVE_MAX));

  assign inst_stall = inst_req & ~inst_ack & ~rst;
  assign data_stall = data_req & ~data_ack & ~rst;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  logic [TW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = ((state == REQ) || (state == WAIT)) && (to_cnt == TO_MAX);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= to_hit;
      if (state == IDLE)
        to_cnt <= '0;
      else if ((state == REQ) || (state == WAIT))
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus_err = 1'b0;
`endif

  // Completion of the latched transaction: a real response, or an aborted one.
  always_comb begin
    fin       = 1'b0;
    fin_rdata = mem_rdata;
    if ((state == WAIT) && mem_rvalid)
      fin = 1'b1;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    if (to_hit) begin
      fin       = 1'b1;
      fin_rdata = 32'hDEADBEEF;
    end
`endif
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_req | data_req) begin
            owner_data <= grant_data;
            mem_req    <= 1'b1;
            mem_wr     <= grant_data & data_wr;
            mem_addr   <= grant_data ? data_addr : inst_addr;
            mem_wdata  <= grant_data ? data_wdata : '0;
            mem_wstrb  <= (grant_data && data_wr) ? data_wstrb : 4'b0000;
            if (!grant_data)
              starve_cnt <= '0;
            else if (inst_req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (!fin && mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        DONE:    state <= IDLE;
        default: ;
      endcase
      // Ack goes to the latched owner even if its request has since been dropped.
      if (fin) begin
        mem_req <= 1'b0;
        state   <= DONE;
        if (owner_data) begin
          data_ack   <= 1'b1;
          data_rdata <= fin_rdata;
        end else begin
          inst_ack   <= 1'b1;
          inst_rdata <= fin_rdata;
        end
      end
    end
  end

endmodule
